// File: rtl/west_feeder_if.sv
`default_nettype none
// west_feeder_if -- vector write port, command handshake and west-edge array outputs.
// Revision 1.0
interface west_feeder_if #(
  parameter int bw  = 4,
  parameter int row = 8
);
  logic              wr;
  logic [row*bw-1:0] wdata;
  logic              full;
  logic              empty;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [7:0]        cmd_len;
  logic [row*bw-1:0] in_w_bus;
  logic [2*row-1:0]  inst_w_bus;
  logic              busy;
  logic              done;

  modport master (
    output wr, wdata, cmd_valid, cmd_op, cmd_len,
    input  full, empty, cmd_ready, in_w_bus, inst_w_bus, busy, done
  );

  modport slave (
    input  wr, wdata, cmd_valid, cmd_op, cmd_len,
    output full, empty, cmd_ready, in_w_bus, inst_w_bus, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/west_feeder.sv
`default_nettype none
// west_feeder -- vector FIFO and command FSM streaming load/execute vectors into the west edge
// of a systolic array, lane r skewed by r cycles. Revision 1.0
module west_feeder #(
  parameter int bw    = 4,
  parameter int row   = 8,
  parameter int depth = 16
) (
  input  logic         clk,
  input  logic         reset,
  west_feeder_if.slave bus
);
  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth + 1);
  localparam int DW = (row > 1) ? $clog2(row) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  logic [row*bw-1:0] mem_q [depth];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  state_t            state_q, state_d;
  logic [7:0]        rem_q, rem_d;
  logic              op_q, op_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              wr_ok;
  logic              issue;
  logic [row*bw-1:0] rd_data;

  assign bus.full      = (count_q == CW'(depth));
  assign bus.empty     = (count_q == '0);
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.cmd_ready = ready_q;

  assign wr_ok   = bus.wr && !bus.full;
  assign issue   = (state_q == ISSUE) && !bus.empty;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_ok);
    rd_ptr_d = rd_ptr_q + AW'(issue);
    count_d  = count_q + CW'(wr_ok) - CW'(issue);
    state_d  = state_q;
    rem_d    = rem_q;
    op_d     = op_q;
    drain_d  = drain_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d  = bus.cmd_op;
          rem_d = bus.cmd_len;
          if (bus.cmd_len == 8'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
      end
      DRAIN: begin
        // Wait until the last vector has left the deepest skew stage.
        drain_d = drain_q + DW'(1);
        if (drain_q == DW'(row - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      rem_q    <= '0;
      op_q     <= 1'b0;
      drain_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      drain_q  <= drain_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= bus.wdata;
    end
  end

  // Row r carries its lane through r+1 registers; stage 0 is the registered issue point.
  for (genvar r = 0; r < row; r++) begin : g_row
    logic [bw-1:0] dat_q [r+1];
    logic [bw-1:0] dat_d [r+1];
    logic [1:0]    ins_q [r+1];
    logic [1:0]    ins_d [r+1];

    always_comb begin
      dat_d[0] = issue ? rd_data[bw*r +: bw] : '0;
      ins_d[0] = issue ? (op_q ? 2'b10 : 2'b01) : 2'b00;
      for (int j = 1; j <= r; j++) begin
        dat_d[j] = dat_q[j-1];
        ins_d[j] = ins_q[j-1];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int j = 0; j <= r; j++) begin
          dat_q[j] <= '0;
          ins_q[j] <= 2'b00;
        end
      end else begin
        for (int j = 0; j <= r; j++) begin
          dat_q[j] <= dat_d[j];
          ins_q[j] <= ins_d[j];
        end
      end
    end

    assign bus.in_w_bus[bw*r +: bw] = dat_q[r];
    assign bus.inst_w_bus[2*r +: 2] = ins_q[r];
  end
endmodule
`default_nettype wire

// File: tb/tb_west_feeder.sv
`default_nettype none
// tb_west_feeder -- directed scenarios plus randomized traffic against a queue-based model.
// Revision 1.0
module tb_west_feeder;
  localparam int BW    = 4;
  localparam int ROW   = 8;
  localparam int DEPTH = 16;
  localparam int VW    = ROW * BW;

  logic clk = 1'b0;
  logic reset;

  west_feeder_if #(.bw(BW), .row(ROW)) bus ();

  west_feeder #(.bw(BW), .row(ROW), .depth(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: FIFO as a queue, command progress as remaining count and done cycle,
  // and a history of what entered row 0 in each cycle (row r sees it r cycles later).
  logic [VW-1:0] q [$];
  int            m_rem     = 0;
  int            m_done_at = 0;
  logic          m_op      = 1'b0;
  logic          m_done    = 1'b0;
  logic [1:0]    hist_ins [64];
  logic [VW-1:0] hist_dat [64];

  always @(posedge clk) begin
    logic iss, full_c, nd;
    if (reset) begin
      q.delete();
      m_rem     = 0;
      m_done_at = 0;
      nd        = 1'b0;
      for (int i = 0; i < 64; i++) begin
        hist_ins[i] = 2'b00;
        hist_dat[i] = '0;
      end
    end else begin
      full_c = (q.size() == DEPTH);
      iss    = (m_rem > 0) && (q.size() > 0);
      nd     = (m_done_at == cyc + 1);
      hist_ins[cyc & 63] = iss ? (m_op ? 2'b10 : 2'b01) : 2'b00;
      hist_dat[cyc & 63] = iss ? q[0] : '0;
      if (iss) begin
        void'(q.pop_front());
        m_rem--;
        if (m_rem == 0) m_done_at = cyc + ROW + 1;
      end else if (m_rem == 0 && cyc >= m_done_at && bus.cmd_valid) begin
        if (bus.cmd_len == 8'd0) begin
          nd = 1'b1;
        end else begin
          m_rem = int'(bus.cmd_len);
          m_op  = bus.cmd_op;
        end
      end
      if (bus.wr && !full_c) q.push_back(bus.wdata);
    end
    m_done = nd;
    cyc++;
  end

  function automatic logic [2*ROW-1:0] exp_inst();
    logic [2*ROW-1:0] v;
    v = '0;
    for (int r = 0; r < ROW; r++) v[2*r +: 2] = hist_ins[(cyc - 1 - r) & 63];
    return v;
  endfunction

  function automatic logic [VW-1:0] exp_data();
    logic [VW-1:0] v;
    logic [VW-1:0] h;
    v = '0;
    for (int r = 0; r < ROW; r++) begin
      h = hist_dat[(cyc - 1 - r) & 63];
      v[BW*r +: BW] = h[BW*r +: BW];
    end
    return v;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    return VW'($urandom);
  endfunction

  task automatic push_vec(input logic [VW-1:0] d);
    @(negedge clk);
    bus.wr    = 1'b1;
    bus.wdata = d;
  endtask

  task automatic offer(input logic op, input logic [7:0] len, output int t);
    @(negedge clk);
    bus.wr        = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = len;
    t = cyc;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) at = cyc;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.inst_w_bus !== '0 || bus.in_w_bus !== '0) begin
      n_bad++;
      $display("FAIL reset_bus inst=%h data=%h required 0/0", bus.inst_w_bus, bus.in_w_bus);
    end
    n_cmp++;
    if ({bus.empty, bus.full, bus.cmd_ready, bus.busy, bus.done} !== 5'b10100) begin
      n_bad++;
      $display("FAIL reset_flags e/f/rdy/busy/done=%b required 10100",
               {bus.empty, bus.full, bus.cmd_ready, bus.busy, bus.done});
    end
    reset = 1'b0;
  endtask

  task automatic test_fill();
    logic [VW-1:0] v [17];
    int t, at;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.full !== (i >= 16)) begin
        n_bad++;
        $display("FAIL fill_full after %0d writes got=%b required %b", i, bus.full, (i >= 16));
      end
      v[i]      = rand_vec();
      bus.wr    = 1'b1;
      bus.wdata = v[i];
    end
    offer(1'b1, 8'd16, t);
    n_cmp++;
    if (bus.full !== 1'b1 || bus.empty !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_overflow full=%b empty=%b required 1/0", bus.full, bus.empty);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.in_w_bus[BW-1:0] !== v[k][BW-1:0] || bus.inst_w_bus[1:0] !== 2'b10) begin
        n_bad++;
        $display("FAIL fill_order pop %0d lane0=%h inst=%b required %h/10",
                 k, bus.in_w_bus[BW-1:0], bus.inst_w_bus[1:0], v[k][BW-1:0]);
      end
    end
    n_cmp++;
    if (bus.empty !== 1'b1) begin
      n_bad++;
      $display("FAIL fill_drop empty=%b required 1 after 16 pops", bus.empty);
    end
    wait_done(20, at);
    n_cmp++;
    if (at != t + 25) begin
      n_bad++;
      $display("FAIL fill_done cycle=%0d required %0d", at, t + 25);
    end
  endtask

  task automatic test_kernel();
    logic [VW-1:0]    v [3];
    logic [2*ROW-1:0] ei;
    logic [VW-1:0]    ed;
    int t, j;
    for (int i = 0; i < 3; i++) begin
      v[i] = rand_vec();
      push_vec(v[i]);
    end
    offer(1'b0, 8'd3, t);
    for (int c = t + 1; c <= t + 14; c++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      ei = '0;
      ed = '0;
      for (int r = 0; r < ROW; r++) begin
        j = c - t - 2 - r;
        if (j >= 0 && j < 3) begin
          ei[2*r +: 2]  = 2'b01;
          ed[BW*r +: BW] = v[j][BW*r +: BW];
        end
      end
      n_cmp++;
      if (bus.inst_w_bus !== ei || bus.in_w_bus !== ed) begin
        n_bad++;
        $display("FAIL kern_bus T+%0d inst=%h data=%h required %h/%h",
                 c - t, bus.inst_w_bus, bus.in_w_bus, ei, ed);
      end
      n_cmp++;
      if (bus.done !== (c == t + 12) || bus.cmd_ready !== (c >= t + 12)) begin
        n_bad++;
        $display("FAIL kern_done T+%0d done=%b rdy=%b required %b/%b",
                 c - t, bus.done, bus.cmd_ready, (c == t + 12), (c >= t + 12));
      end
    end
  endtask

  task automatic test_starve();
    logic [VW-1:0]    v [3];
    int               ia [3];
    logic [2*ROW-1:0] ei;
    logic [VW-1:0]    ed;
    int t;
    for (int i = 0; i < 3; i++) v[i] = rand_vec();
    push_vec(v[0]);
    offer(1'b1, 8'd3, t);
    ia[0] = t + 1;
    ia[1] = t + 4;
    ia[2] = t + 5;
    for (int c = t + 1; c <= t + 16; c++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      ei = '0;
      ed = '0;
      for (int r = 0; r < ROW; r++) begin
        for (int k = 0; k < 3; k++) begin
          if (c - 1 - r == ia[k]) begin
            ei[2*r +: 2]   = 2'b10;
            ed[BW*r +: BW] = v[k][BW*r +: BW];
          end
        end
      end
      n_cmp++;
      if (bus.inst_w_bus !== ei || bus.in_w_bus !== ed) begin
        n_bad++;
        $display("FAIL starve_bus T+%0d inst=%h data=%h required %h/%h",
                 c - t, bus.inst_w_bus, bus.in_w_bus, ei, ed);
      end
      n_cmp++;
      if (bus.done !== (c == t + 14)) begin
        n_bad++;
        $display("FAIL starve_done T+%0d done=%b required %b", c - t, bus.done, (c == t + 14));
      end
      bus.wr    = (c == t + 3) || (c == t + 4);
      bus.wdata = (c == t + 3) ? v[1] : v[2];
    end
    bus.wr = 1'b0;
  endtask

  task automatic test_len0();
    int t;
    offer(1'b1, 8'd0, t);
    for (int c = t + 1; c <= t + 10; c++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      n_cmp++;
      if (bus.inst_w_bus !== '0 || bus.done !== (c == t + 1) || bus.cmd_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL len0 T+%0d inst=%h done=%b rdy=%b required 0/%b/1",
                 c - t, bus.inst_w_bus, bus.done, bus.cmd_ready, (c == t + 1));
      end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    for (int i = 0; i < 5; i++) push_vec(rand_vec());
    offer(1'b0, 8'd5, t);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (bus.inst_w_bus !== '0 || bus.in_w_bus !== '0 ||
        {bus.empty, bus.full, bus.cmd_ready, bus.busy, bus.done} !== 5'b10100) begin
      n_bad++;
      $display("FAIL rstmid_outputs inst=%h data=%h e/f/rdy/busy/done=%b required 0/0/10100",
               bus.inst_w_bus, bus.in_w_bus,
               {bus.empty, bus.full, bus.cmd_ready, bus.busy, bus.done});
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.done !== 1'b0 || bus.inst_w_bus !== '0 || bus.empty !== 1'b1) begin
        n_bad++;
        $display("FAIL rstmid_after +%0d done=%b inst=%h empty=%b required 0/0/1",
                 i, bus.done, bus.inst_w_bus, bus.empty);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] v [3];
    int t, d, at;
    for (int i = 0; i < 3; i++) begin
      v[i] = rand_vec();
      push_vec(v[i]);
    end
    offer(1'b0, 8'd2, t);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    wait_done(30, d);
    n_cmp++;
    if (d != t + 11 || bus.cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_first_done cycle=%0d rdy=%b required %0d/1", d, bus.cmd_ready, t + 11);
    end
    if (d < 0) return;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 1'b1;
    bus.cmd_len   = 8'd1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_accept busy=%b rdy=%b required 1/0", bus.busy, bus.cmd_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.inst_w_bus[1:0] !== 2'b10 || bus.in_w_bus[BW-1:0] !== v[2][BW-1:0]) begin
      n_bad++;
      $display("FAIL b2b_issue inst0=%b lane0=%h required 10/%h",
               bus.inst_w_bus[1:0], bus.in_w_bus[BW-1:0], v[2][BW-1:0]);
    end
    wait_done(20, at);
    n_cmp++;
    if (at != d + 10) begin
      n_bad++;
      $display("FAIL b2b_second_done cycle=%0d required %0d", at, d + 10);
    end
  endtask

  task automatic test_random();
    logic rdy, both;
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      rdy = (m_rem == 0) && (cyc >= m_done_at);
      n_cmp++;
      if (bus.inst_w_bus !== exp_inst()) begin
        n_bad++;
        $display("FAIL rnd_inst cyc=%0d got=%h required %h", cyc, bus.inst_w_bus, exp_inst());
      end
      n_cmp++;
      if (bus.in_w_bus !== exp_data()) begin
        n_bad++;
        $display("FAIL rnd_data cyc=%0d got=%h required %h", cyc, bus.in_w_bus, exp_data());
      end
      n_cmp++;
      if ({bus.done, bus.cmd_ready, bus.busy, bus.empty, bus.full} !==
          {m_done, rdy, !rdy, q.size() == 0, q.size() == DEPTH}) begin
        n_bad++;
        $display("FAIL rnd_flags cyc=%0d done/rdy/busy/e/f=%b required %b", cyc,
                 {bus.done, bus.cmd_ready, bus.busy, bus.empty, bus.full},
                 {m_done, rdy, !rdy, q.size() == 0, q.size() == DEPTH});
      end
      both = 1'b0;
      for (int r = 0; r < ROW; r++) if (bus.inst_w_bus[2*r +: 2] === 2'b11) both = 1'b1;
      n_cmp++;
      if (both !== 1'b0) begin
        n_bad++;
        $display("FAIL rnd_inst_excl cyc=%0d inst=%h has a row at 11", cyc, bus.inst_w_bus);
      end
      reset         = ($urandom_range(0, 199) == 0);
      bus.wr        = ($urandom_range(0, 9) < 6);
      bus.wdata     = rand_vec();
      bus.cmd_valid = (i < 800) && ($urandom_range(0, 9) < 3);
      bus.cmd_op    = 1'($urandom_range(0, 1));
      bus.cmd_len   = 8'($urandom_range(0, 5));
    end
    reset         = 1'b0;
    bus.wr        = 1'b0;
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      hist_ins[i] = 2'b00;
      hist_dat[i] = '0;
    end
    reset         = 1'b1;
    bus.wr        = 1'b0;
    bus.wdata     = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_len   = 8'd0;
    test_reset();
    test_fill();
    test_kernel();
    test_starve();
    test_len0();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
